// File: rtl/nv_nvdla_sdp_wdma_arb_pkg.sv
// Shared types and defaults for the SDP write-DMA request arbiter.
// Holds the FSM encoding, packet-type codes and the size-to-beats conversion.
package nv_nvdla_sdp_wdma_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic PKT_CMD  = 1'b0;
    localparam logic PKT_DATA = 1'b1;

    localparam int unsigned DEF_SIZE_LSB = 64;
    localparam int unsigned DEF_SIZE_W   = 13;
    localparam int unsigned DEF_ACK_BIT  = 77;

    // size counts 32B atoms minus one; one 64B beat carries two atoms
    function automatic logic [31:0] size_to_beats(input logic [31:0] size);
        return (size >> 1) + 32'd1;
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_wdma_arb_idfifo.sv
// Small flop FIFO of client ids awaiting a write-complete acknowledgement.
// A pop on empty is ignored; push while full is accepted only alongside a pop.
module nv_nvdla_sdp_wdma_arb_idfifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_id,
    input  logic         pop,
    output logic [W-1:0] pop_id,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW+1)'(DEPTH));
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        pop_id  = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_wdma_arb.sv
// Packet-atomic round-robin arbiter for the SDP write-DMA request channel.
// Grant is held from a client's command through its last data beat; ack owners are queued for complete routing.
module nv_nvdla_sdp_wdma_arb
    import nv_nvdla_sdp_wdma_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned PD_W      = 514,
    parameter int unsigned ACK_DEPTH = 8,
    parameter int unsigned SIZE_LSB  = DEF_SIZE_LSB,
    parameter int unsigned SIZE_W    = DEF_SIZE_W,
    parameter int unsigned ACK_BIT   = DEF_ACK_BIT
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ-1:0]      req_type,
    input  logic [NREQ*PD_W-1:0] req_pd,
    output logic                 dma_wr_req_vld,
    input  logic                 dma_wr_req_rdy,
    output logic                 dma_wr_req_type,
    output logic [PD_W-1:0]      dma_wr_req_pd,
    input  logic                 wr_rsp_complete,
    output logic [NREQ-1:0]      client_complete,
    output logic                 arb_busy,
    output logic                 err_proto
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [IDW-1:0]    owner;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    winner;
    logic [IDW-1:0]    cand;
    logic              win_found;
    logic [NREQ-1:0]   eligible;
    logic [SIZE_W-1:0] beat_cnt;
    logic [SIZE_W-1:0] cmd_size;

    logic              own_vld;
    logic              own_type;
    logic [PD_W-1:0]   own_pd;

    logic              grant;
    logic              cmd_accept;
    logic              data_accept;
    logic              idle_err;
    logic              ack_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [IDW-1:0]    head_id;

    always_comb begin
        own_vld  = req_vld[owner];
        own_type = req_type[owner];
        own_pd   = req_pd[owner*PD_W +: PD_W];
        cmd_size = own_pd[SIZE_LSB +: SIZE_W];
        eligible = req_vld & ~req_type;
    end

    // First eligible client at or after rr_ptr, searching cyclically
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        grant    = (state == ST_IDLE) & win_found & ~fifo_full;
        idle_err = (state == ST_IDLE) & req_vld[rr_ptr] & (req_type[rr_ptr] == PKT_DATA);
        arb_busy = (state != ST_IDLE) | ~fifo_empty;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        req_rdy         = '0;
        dma_wr_req_vld  = 1'b0;
        dma_wr_req_type = PKT_CMD;
        dma_wr_req_pd   = '0;
        cmd_accept      = 1'b0;
        data_accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                dma_wr_req_vld  = own_vld;
                dma_wr_req_type = own_type;
                dma_wr_req_pd   = own_pd;
                req_rdy[owner]  = dma_wr_req_rdy;
                if (own_vld && dma_wr_req_rdy && own_type == PKT_CMD) begin
                    cmd_accept = 1'b1;
                    state_nxt  = ST_DATA;
                end
            end
            ST_DATA: begin
                dma_wr_req_vld  = own_vld;
                dma_wr_req_type = own_type;
                dma_wr_req_pd   = own_pd;
                req_rdy[owner]  = dma_wr_req_rdy;
                if (own_vld && dma_wr_req_rdy) begin
                    data_accept = 1'b1;
                    if (beat_cnt == SIZE_W'(1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Packet boundary comes only from beat_cnt, whatever type the beats carry
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (grant) begin
                owner <= winner;
            end
            if (cmd_accept) begin
                beat_cnt <= SIZE_W'(size_to_beats(32'(cmd_size)));
            end else if (data_accept) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
            if (data_accept && beat_cnt == SIZE_W'(1)) begin
                rr_ptr <= (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

    assign ack_push = cmd_accept & own_pd[ACK_BIT];

    nv_nvdla_sdp_wdma_arb_idfifo #(
        .DEPTH (ACK_DEPTH),
        .W     (IDW)
    ) u_idfifo (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .push    (ack_push),
        .push_id (owner),
        .pop     (wr_rsp_complete),
        .pop_id  (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            client_complete <= '0;
            err_proto       <= 1'b0;
        end else begin
            client_complete <= '0;
            if (wr_rsp_complete && !fifo_empty) begin
                client_complete[head_id] <= 1'b1;
            end
            if ((wr_rsp_complete && fifo_empty) || idle_err) begin
                err_proto <= 1'b1;
            end
        end
    end

endmodule
